mul_iter: RTL and testbench
===========================

MUL_ITER -- requirements
Module: mul_iter

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand width; the result is 2*WIDTH bits wide.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high; the master drives it as rst|flushE|exceptionoccur.
REQ-004 The block SHALL have port a, input, WIDTH bits: multiplicand.
REQ-005 The block SHALL have port b, input, WIDTH bits: multiplier.
REQ-006 The block SHALL have port sign, input, 1 bit: 1 = signed (MULT), 0 = unsigned (MULTU).
REQ-007 The block SHALL have port opn_valid, input, 1 bit: master operands valid.
REQ-008 The block SHALL have port res_ready, input, 1 bit: master can accept the result.
REQ-009 The block SHALL have port res_valid, output, 1 bit: result available.
REQ-010 The block SHALL have port result, output, 2*WIDTH bits: {hi,lo} product.
REQ-011 The block SHALL have port busy, output, 1 bit: an operation is in CALC or DONE.

Function
REQ-012 The block SHALL implement a 3-state FSM with states IDLE, CALC and DONE.
REQ-013 IDLE, opn_valid=1 at an edge (the acceptance edge E0): latch |a| and |b|, taking the two's-complement magnitude only when sign=1 and the MSB is 1; latch neg = sign & (a[MSB]^b[MSB]); clear the accumulator and the iteration counter; go to CALC.
REQ-014 IDLE, opn_valid=0: remain in IDLE; res_valid=0, busy=0.
REQ-015 CALC SHALL perform one radix-2 shift-add iteration per edge, LSB-first on the latched multiplier, for exactly WIDTH edges (E1..E_WIDTH).
REQ-016 Changes on a, b or sign after E0 SHALL be ignored.
REQ-017 At edge E_WIDTH the FSM SHALL go to DONE and load result with the 2*WIDTH product, negated (two's complement, full 2*WIDTH bits) when neg=1.
REQ-018 res_valid SHALL first be 1 in the cycle after E_WIDTH, giving a latency of WIDTH cycles (32 by default) from acceptance to res_valid.
REQ-019 DONE: res_valid=1 and result SHALL be held stable while res_ready=0, with no timeout.
REQ-020 DONE with res_valid & res_ready at an edge: the handshake completes; go to IDLE; res_valid=0 in the next cycle; result SHALL retain its value until the next DONE load.
REQ-021 DONE with opn_valid=0 and res_ready=0 at an edge: abort to IDLE, because the master withdrew the request.
REQ-022 CALC with opn_valid=0 at an edge: abort to IDLE; no result is loaded; res_valid stays 0.
REQ-023 Back-to-back operation: after a completed handshake, a new operation SHALL be accepted only from IDLE, at the earliest one cycle after the completion edge; opn_valid in the DONE completion cycle SHALL NOT start a new operation.
REQ-024 busy SHALL be 1 exactly while the state is CALC or DONE.
REQ-025 Products with zero operands SHALL yield 0 with no sign artefact (never 0xFFFF...0000 patterns); neg with a zero product SHALL still give 0.
REQ-026 Signed operand 0x80000000: the magnitude 0x80000000 SHALL be treated as an unsigned 32-bit value and the iteration SHALL still produce the exact product.

Reset
REQ-027 With rst=1 at an edge, in any state: state becomes IDLE, res_valid=0, busy=0, result=0, and the counter, accumulator and neg are cleared.
REQ-028 rst SHALL have priority over every other input, including rst asserted in the same edge as E0 or as the completion edge.
REQ-029 After rst deasserts, the first acceptance SHALL be possible at the next edge with opn_valid=1.

Verification
REQ-030 Unsigned 0xFFFFFFFF x 0xFFFFFFFF, sign=0, res_ready=1 -> res_valid rises 32 cycles after E0; result=0xFFFFFFFE00000001; res_valid high for exactly 1 cycle.
REQ-031 Signed -3 (0xFFFFFFFD) x 5 -> result=0xFFFFFFFFFFFFFFF1; signed 0x80000000 x 0x80000000 -> result=0x4000000000000000.
REQ-032 Unsigned 7 x 6 with res_ready=0 for 10 cycles after res_valid, a/b toggled randomly meanwhile -> result stays 0x2A and res_valid stays 1; IDLE one cycle after res_ready=1.
REQ-033 rst pulsed at cycle 15 of CALC -> next cycle busy=0, res_valid=0, result=0; a new op 2 x 3 then returns 6 after 32 cycles.
REQ-034 opn_valid dropped at cycle 10 of CALC -> IDLE, res_valid never asserts; signed 0 x -1 afterwards -> result=0.

Source files
------------

// File: rtl/mul_iter.sv
// mul_iter: iterative radix-2 shift-add multiplier, signed or unsigned.
// An operation is accepted from IDLE when opn_valid is high. The operand
// magnitudes and the product sign are captured at that edge, then one
// partial product is added per cycle for WIDTH cycles. The {hi,lo} product
// is presented with res_valid and held until the master takes it.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset (rst|flushE|exceptionoccur)
//   a         in   WIDTH      multiplicand
//   b         in   WIDTH      multiplier
//   sign      in   1 = signed (MULT), 0 = unsigned (MULTU)
//   opn_valid in   operands valid; must stay high for the whole operation
//   res_ready in   master accepts the result
//   res_valid out  result available (state DONE)
//   result    out  2*WIDTH    {hi,lo} product, held until the next load
//   busy      out  state is CALC or DONE
//
// state | meaning
// IDLE  | waiting for opn_valid
// CALC  | one shift-add iteration per cycle, WIDTH cycles
// DONE  | result valid, waiting for res_ready (or withdrawal of opn_valid)

module mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sign,
  input  logic               opn_valid,
  input  logic               res_ready,
  output logic               res_valid,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               neg_q, neg_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] acc_sum;

  // The magnitude of the most negative value is itself; read as unsigned
  // it is exact, so no special case is needed.
  assign a_mag = (sign && a[WIDTH-1]) ? -a : a;
  assign b_mag = (sign && b[WIDTH-1]) ? -b : b;

  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (opn_valid) begin
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          neg_d    = sign & (a[WIDTH-1] ^ b[WIDTH-1]);
          // Down-counter: terminal count 0 marks the last iteration.
          cnt_d    = CW'(WIDTH - 1);
          state_d  = CALC;
        end
      end
      CALC: begin
        if (!opn_valid) begin
          state_d = IDLE;
        end else begin
          acc_d    = acc_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          if (cnt_q == '0) begin
            // Negating a zero product gives zero, so no sign artefact.
            result_d = neg_q ? -acc_sum : acc_sum;
            state_d  = DONE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      DONE: begin
        if (res_ready || !opn_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
    end
  end

  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;

endmodule

// File: tb/tb_mul_iter.sv
module tb_mul_iter;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   a, b;
  logic           sign, opn_valid, res_ready;
  logic           res_valid, busy;
  logic [2*W-1:0] result;

  int n_pass  = 0;
  int n_total = 0;

  logic [2*W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0]   va;
    logic [W-1:0]   vb;
    logic           vs;
    logic [2*W-1:0] vexp;
  } vec_t;

  vec_t vecs[12];

  mul_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .sign(sign),
    .opn_valid(opn_valid), .res_ready(res_ready),
    .res_valid(res_valid), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1 ms");
    $fatal(1);
  end

  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
    logic signed [2*W-1:0] xs, ys;
    if (s) begin
      xs = {{W{x[W-1]}}, x};
      ys = {{W{y[W-1]}}, y};
      return xs * ys;
    end
    return {{W{1'b0}}, x} * {{W{1'b0}}, y};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
  endtask

  task automatic scramble();
    a    = $urandom;
    b    = $urandom;
    sign = 1'($urandom);
  endtask

  // Drive operands at a falling edge; returns at the falling edge after E0.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic ts, input logic rdy);
    @(negedge clk);
    a = ta; b = tb_v; sign = ts; opn_valid = 1'b1; res_ready = rdy;
    @(negedge clk);
    scramble();
  endtask

  // Counts falling edges after E0 until res_valid, bounded.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (res_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
      scramble();
    end
    if (lat >= 100) chk("res_valid_timeout", 64'(res_valid), 64'd1);
  endtask

  task automatic pop_check(input string nm);
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL %s: result 0x%h arrived, expected an entry in the scoreboard", nm, result);
    end else begin
      chk(nm, result, exp_q.pop_front());
    end
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic ts, input logic [2*W-1:0] e);
    int lat;
    exp_q.push_back(e);
    start_op(ta, tb_v, ts, 1'b1);
    chk({nm, "_busy"}, 64'(busy), 64'd1);
    wait_valid(lat);
    chk({nm, "_lat"}, 64'(lat), 64'd32);
    pop_check({nm, "_res"});
    opn_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_pulse"}, 64'({res_valid, busy}), 64'd0);
  endtask

  initial begin
    int lat;
    int seen;

    vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
    vecs[1] = '{32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1};
    vecs[2] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001};
    vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000};
    vecs[5] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000};
    vecs[6] = '{32'h0000_0000, 32'h1234_5678, 1'b0, 64'h0};
    vecs[7] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 64'h0};
    for (int i = 8; i < 12; i++) begin
      vecs[i].va   = $urandom;
      vecs[i].vb   = $urandom;
      vecs[i].vs   = 1'(i % 2);
      vecs[i].vexp = model(vecs[i].va, vecs[i].vb, vecs[i].vs);
    end

    rst = 1'b1; a = '0; b = '0; sign = 1'b0; opn_valid = 1'b0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_valid", 64'(res_valid), 64'd0);
    chk("reset_result", result, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vs, vecs[i].vexp);
    end

    // Result held while the master stalls, inputs wiggling meanwhile.
    exp_q.push_back(64'h2A);
    start_op(32'd7, 32'd6, 1'b0, 1'b0);
    wait_valid(lat);
    pop_check("hold_first");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("hold_valid%0d", i), 64'(res_valid), 64'd1);
      chk($sformatf("hold_result%0d", i), result, 64'h2A);
      scramble();
    end
    res_ready = 1'b1; opn_valid = 1'b0;
    @(negedge clk);
    chk("hold_release_busy", 64'(busy), 64'd0);
    chk("hold_release_keep", result, 64'h2A);

    // Back-to-back: opn_valid held across the completion edge must not restart.
    exp_q.push_back(64'h10);
    start_op(32'd4, 32'd4, 1'b0, 1'b1);
    wait_valid(lat);
    pop_check("b2b_res");
    @(negedge clk);
    chk("b2b_idle_gap", 64'(busy), 64'd0);
    @(negedge clk);
    chk("b2b_accept", 64'(busy), 64'd1);
    opn_valid = 1'b0;
    @(negedge clk);
    chk("b2b_abort", 64'(busy), 64'd0);

    // Master withdraws in DONE without taking the result.
    exp_q.push_back(64'd81);
    start_op(32'd9, 32'd9, 1'b0, 1'b0);
    wait_valid(lat);
    pop_check("done_abort_res");
    opn_valid = 1'b0;
    @(negedge clk);
    chk("done_abort_busy", 64'(busy), 64'd0);
    chk("done_abort_keep", result, 64'd81);

    // Reset mid-CALC, then acceptance on the first edge after release.
    start_op(32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 1'b1);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_calc_busy", 64'(busy), 64'd0);
    chk("rst_calc_valid", 64'(res_valid), 64'd0);
    chk("rst_calc_result", result, 64'd0);
    rst = 1'b0;
    a = 32'd2; b = 32'd3; sign = 1'b0; opn_valid = 1'b1; res_ready = 1'b1;
    exp_q.push_back(64'd6);
    @(negedge clk);
    chk("rst_release_accept", 64'(busy), 64'd1);
    wait_valid(lat);
    chk("rst_release_lat", 64'(lat), 64'd32);
    pop_check("rst_release_res");
    opn_valid = 1'b0;
    @(negedge clk);

    // Reset in the same edge as E0.
    a = 32'd5; b = 32'd5; opn_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    chk("rst_e0_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_e0_then_accept", 64'(busy), 64'd1);
    opn_valid = 1'b0;
    @(negedge clk);
    chk("calc_abort_busy", 64'(busy), 64'd0);

    // Reset in the same edge as the completion handshake.
    start_op(32'd3, 32'd3, 1'b0, 1'b1);
    wait_valid(lat);
    chk("rst_done_pre", result, 64'd9);
    rst = 1'b1; opn_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_done_result", result, 64'd0);
    chk("rst_done_valid", 64'(res_valid), 64'd0);

    // opn_valid dropped at cycle 10 of CALC: nothing is ever presented.
    start_op(32'h1234, 32'h5678, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    opn_valid = 1'b0;
    @(negedge clk);
    chk("drop_busy", 64'(busy), 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    chk("drop_no_valid", 64'(seen), 64'd0);
    run_op("zero_neg", 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 64'd0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
